// File: rtl/inst_sequencer_pkg.sv
// Shared types for the instruction sequencer: FSM states, opcode classes,
// fixed opcodes and the legality/classification helpers used at dispatch.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_VEXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_SCALAR, C_VECTOR, C_LOAD, C_STORE, C_JMP, C_BZ, C_HALT, C_ILLEGAL
  } class_e;

  localparam logic [5:0] OP_LOAD  = 6'b100000;
  localparam logic [5:0] OP_STORE = 6'b100001;
  localparam logic [5:0] OP_JMP   = 6'b110000;
  localparam logic [5:0] OP_BZ    = 6'b110001;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  function automatic logic is_legal(input logic [5:0] op);
    logic ok;
    case (op[5:4])
      2'b00:   ok = !op[3];
      2'b01:   ok = (op[3:0] <= 4'd5);
      2'b10:   ok = (op == OP_LOAD) || (op == OP_STORE);
      default: ok = (op == OP_JMP) || (op == OP_BZ) || (op == OP_HALT);
    endcase
    return ok;
  endfunction

  function automatic class_e op_class(input logic [5:0] op);
    class_e c;
    if (!is_legal(op)) begin
      c = C_ILLEGAL;
    end else begin
      case (op[5:4])
        2'b00:   c = C_SCALAR;
        2'b01:   c = C_VECTOR;
        2'b10:   c = op[0] ? C_STORE : C_LOAD;
        default: c = (op == OP_JMP) ? C_JMP : (op == OP_BZ) ? C_BZ : C_HALT;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Handshake/control bundle between the sequencer (master) and the
// instruction/data memories plus datapath (slave).
interface inst_sequencer_if #(parameter int LANES = 4);
  logic                       start;
  logic [5:0]                 opcode;
  logic                       flag_z;
  logic                       imem_ack;
  logic                       dmem_ack;
  logic                       imem_req;
  logic                       ir_load;
  logic                       dmem_req;
  logic                       dmem_we;
  logic [3:0]                 alu_op;
  logic                       alu_src_imm;
  logic [$clog2(LANES)-1:0]   vec_lane;
  logic                       reg_we;
  logic                       vreg_we;
  logic                       pc_we;
  logic                       pc_sel_branch;
  logic                       halted;
  logic                       illegal;

  modport master (
    input  start, opcode, flag_z, imem_ack, dmem_ack,
    output imem_req, ir_load, dmem_req, dmem_we, alu_op, alu_src_imm,
           vec_lane, reg_we, vreg_we, pc_we, pc_sel_branch, halted, illegal
  );

  modport slave (
    output start, opcode, flag_z, imem_ack, dmem_ack,
    input  imem_req, ir_load, dmem_req, dmem_we, alu_op, alu_src_imm,
           vec_lane, reg_we, vreg_we, pc_we, pc_sel_branch, halted, illegal
  );
endinterface

// File: rtl/inst_sequencer_lane_counter.sv
// Vector lane index: counts while enabled, clears when the last lane retires.
module lane_counter #(
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(LANES)-1:0] lane,
  output logic                     last
);
  localparam int LW = $clog2(LANES);

  logic [LW-1:0] lane_q, lane_d;

  always_comb begin
    lane_d = lane_q;
    if (clr)      lane_d = '0;
    else if (inc) lane_d = lane_q + LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lane_q <= '0;
    else        lane_q <= lane_d;
  end

  assign lane = lane_q;
  assign last = (lane_q == LW'(LANES - 1));
endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle fetch/decode/dispatch controller. Strobes are decodes of the
// registered state; only ack- and flag-qualified strobes look at inputs.
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_sequencer_if.master  bus
);
  localparam int LW = $clog2(LANES);

  state_e        state_q, state_d;
  class_e        cls_q, cls_d;
  logic [3:0]    fn_q, fn_d;
  logic          illegal_q, illegal_d;

  logic          lane_inc, lane_clr, lane_last;
  logic [LW-1:0] lane;

  lane_counter #(.LANES(LANES)) u_lane (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (lane_clr),
    .inc   (lane_inc),
    .lane  (lane),
    .last  (lane_last)
  );

  assign lane_inc = (state_q == S_VEXEC);
  assign lane_clr = lane_inc && lane_last;

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    fn_d      = fn_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  if (bus.imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        // Class and low opcode bits are captured here so later states do
        // not depend on the decoder holding its output.
        cls_d = op_class(bus.opcode);
        fn_d  = bus.opcode[3:0];
        case (cls_d)
          C_SCALAR, C_JMP, C_BZ: state_d = S_EXEC;
          C_VECTOR:              state_d = S_VEXEC;
          C_LOAD, C_STORE:       state_d = S_MEM;
          C_HALT:                state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC:   state_d = (cls_q == C_SCALAR) ? S_WB : S_FETCH;
      S_VEXEC:  if (lane_last) state_d = S_WB;
      S_MEM:    if (bus.dmem_ack) state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_SCALAR;
      fn_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      fn_q      <= fn_d;
      illegal_q <= illegal_d;
    end
  end

  logic in_fetch, in_exec, in_vexec, in_mem, in_wb, is_branch;
  assign in_fetch  = (state_q == S_FETCH);
  assign in_exec   = (state_q == S_EXEC);
  assign in_vexec  = (state_q == S_VEXEC);
  assign in_mem    = (state_q == S_MEM);
  assign in_wb     = (state_q == S_WB);
  assign is_branch = (cls_q == C_JMP) || (cls_q == C_BZ);

  assign bus.imem_req      = in_fetch;
  assign bus.ir_load       = in_fetch && bus.imem_ack;
  assign bus.dmem_req      = in_mem;
  assign bus.dmem_we       = in_mem && (cls_q == C_STORE);
  assign bus.alu_op        = (in_exec || in_vexec) ? fn_q : 4'd0;
  assign bus.alu_src_imm   = ((in_exec && cls_q == C_SCALAR) || in_vexec) && fn_q[0];
  assign bus.vec_lane      = lane;
  assign bus.reg_we        = in_wb && (cls_q != C_VECTOR);
  assign bus.vreg_we       = in_vexec;
  // Stores retire on the ack cycle; every other class retires via WB or EXEC.
  assign bus.pc_we         = in_wb || (in_exec && is_branch) ||
                             (in_mem && cls_q == C_STORE && bus.dmem_ack);
  assign bus.pc_sel_branch = in_exec && ((cls_q == C_JMP) || (cls_q == C_BZ && bus.flag_z));
  assign bus.halted        = (state_q == S_HALT);
  assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// Randomized check of the sequencer against a per-instruction cycle-trace model.
module tb_inst_sequencer;
  localparam int LANES = 4;
  localparam int LW    = $clog2(LANES);

  localparam int K_SC = 0, K_VEC = 1, K_LD = 2, K_ST = 3, K_JMP = 4, K_BZ = 5,
                 K_HALT = 6, K_ILL = 7;

  typedef struct packed {
    logic          imem_req;
    logic          ir_load;
    logic          dmem_req;
    logic          dmem_we;
    logic [3:0]    alu_op;
    logic          alu_src_imm;
    logic [LW-1:0] vec_lane;
    logic          reg_we;
    logic          vreg_we;
    logic          pc_we;
    logic          pc_sel_branch;
    logic          halted;
    logic          illegal;
  } outs_t;

  typedef struct {
    logic       ia;
    logic       da;
    logic       fz;
    logic       st;
    logic [5:0] op;
    outs_t      e;
    string      tag;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_sequencer_if #(.LANES(LANES)) bus ();
  inst_sequencer #(.LANES(LANES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   checks   = 0;
  int   failures = 0;
  cyc_t q[$];

  task automatic check_eq(input string tag, input outs_t obs, input outs_t exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic outs_t obs();
    outs_t o;
    o.imem_req      = bus.imem_req;
    o.ir_load       = bus.ir_load;
    o.dmem_req      = bus.dmem_req;
    o.dmem_we       = bus.dmem_we;
    o.alu_op        = bus.alu_op;
    o.alu_src_imm   = bus.alu_src_imm;
    o.vec_lane      = bus.vec_lane;
    o.reg_we        = bus.reg_we;
    o.vreg_we       = bus.vreg_we;
    o.pc_we         = bus.pc_we;
    o.pc_sel_branch = bus.pc_sel_branch;
    o.halted        = bus.halted;
    o.illegal       = bus.illegal;
    return o;
  endfunction

  // Reference classification straight from the opcode table.
  function automatic int kind(input logic [5:0] op);
    if (op == 6'b111111) return K_HALT;
    if (op == 6'b110000) return K_JMP;
    if (op == 6'b110001) return K_BZ;
    if (op == 6'b100000) return K_LD;
    if (op == 6'b100001) return K_ST;
    if (op[5:4] == 2'b00 && op[3] == 1'b0) return K_SC;
    if (op[5:4] == 2'b01 && int'(op[3:0]) <= 5) return K_VEC;
    return K_ILL;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic zero_inputs();
    bus.start = 1'b0; bus.opcode = '0; bus.flag_z = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
  endtask

  task automatic push(input logic ia, da, fz, st, input logic [5:0] op,
                      input outs_t e, input string tag);
    cyc_t c;
    c.ia = ia; c.da = da; c.fz = fz; c.st = st; c.op = op; c.e = e; c.tag = tag;
    q.push_back(c);
  endtask

  task automatic start_prog();
    push(1'b0, rb(), rb(), 1'b1, 6'($urandom), '0, "idle_start");
  endtask

  // Expected cycle-by-cycle outputs for one instruction, from FETCH to retire.
  task automatic build(input logic [5:0] op, input int idly, input int ddly, input logic fzv);
    outs_t e;
    int    k = kind(op);
    string t;
    for (int i = 0; i <= idly; i++) begin
      e = '0; e.imem_req = 1'b1; e.ir_load = (i == idly);
      push(i == idly, rb(), rb(), rb(), 6'($urandom), e, $sformatf("fetch op=%b", op));
    end
    push(rb(), rb(), rb(), rb(), op, '0, $sformatf("decode op=%b", op));
    case (k)
      K_SC: begin
        e = '0; e.alu_op = op[3:0]; e.alu_src_imm = op[0];
        push(rb(), rb(), rb(), rb(), op, e, $sformatf("exec op=%b", op));
        e = '0; e.pc_we = 1'b1; e.reg_we = 1'b1;
        push(rb(), rb(), rb(), rb(), op, e, $sformatf("wb op=%b", op));
      end
      K_VEC: begin
        for (int l = 0; l < LANES; l++) begin
          e = '0; e.vreg_we = 1'b1; e.vec_lane = LW'(l);
          e.alu_op = op[3:0]; e.alu_src_imm = op[0];
          push(rb(), rb(), rb(), rb(), op, e, $sformatf("vexec%0d op=%b", l, op));
        end
        e = '0; e.pc_we = 1'b1;
        push(rb(), rb(), rb(), rb(), op, e, $sformatf("wb op=%b", op));
      end
      K_LD, K_ST: begin
        for (int i = 0; i <= ddly; i++) begin
          e = '0; e.dmem_req = 1'b1; e.dmem_we = (k == K_ST);
          e.pc_we = (k == K_ST) && (i == ddly);
          push(rb(), i == ddly, rb(), rb(), op, e, $sformatf("mem%0d op=%b", i, op));
        end
        if (k == K_LD) begin
          e = '0; e.pc_we = 1'b1; e.reg_we = 1'b1;
          push(rb(), rb(), rb(), rb(), op, e, $sformatf("wb op=%b", op));
        end
      end
      K_JMP, K_BZ: begin
        e = '0; e.alu_op = op[3:0]; e.pc_we = 1'b1;
        e.pc_sel_branch = (k == K_JMP) ? 1'b1 : fzv;
        push(rb(), rb(), fzv, rb(), op, e, $sformatf("branch fz=%0b op=%b", fzv, op));
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          e = '0; e.halted = 1'b1; e.illegal = (k == K_ILL);
          t = $sformatf("halt%0d op=%b", i, op);
          push(rb(), rb(), rb(), rb(), op, e, t);
        end
      end
    endcase
  endtask

  task automatic run_trace(input int abort_at);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      bus.imem_ack = q[i].ia; bus.dmem_ack = q[i].da; bus.flag_z = q[i].fz;
      bus.start = q[i].st; bus.opcode = q[i].op;
      #2;
      check_eq(q[i].tag, obs(), q[i].e);
      if (i == abort_at) begin
        #1 rst_n = 1'b0;
        #1 check_eq($sformatf("async_reset@%s", q[i].tag), obs(), '0);
        zero_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
    q.delete();
    zero_inputs();
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    #2 check_eq("reset", obs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [5:0] rand_legal();
    logic [5:0] op;
    do op = 6'($urandom); while (kind(op) == K_HALT || kind(op) == K_ILL);
    return op;
  endfunction

  function automatic logic [5:0] rand_illegal();
    logic [5:0] op;
    do op = 6'($urandom); while (kind(op) != K_ILL);
    return op;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    zero_inputs();
    rst_n = 1'b0;
    do_reset();

    // Directed program through every class, ending on an illegal opcode.
    start_prog();
    build(6'b000001, 0, 0, 1'b0);
    build(6'b010000, 0, 0, 1'b0);
    build(6'b100001, 0, 3, 1'b0);
    build(6'b110001, 0, 0, 1'b1);
    build(6'b110001, 0, 0, 1'b0);
    build(6'b110000, 1, 0, 1'b0);
    build(6'b100000, 2, 1, 1'b0);
    build(6'b001000, 0, 0, 1'b0);
    run_trace(-1);

    // Reset at vector lane 2, then refetch must restart from lane 0.
    do_reset();
    start_prog();
    build(6'b010011, 0, 0, 1'b0);
    run_trace(5);
    start_prog();
    build(6'b010101, 1, 0, 1'b0);
    build(6'b111111, 0, 0, 1'b0);
    run_trace(-1);

    // Reset while a store is still waiting for its ack.
    do_reset();
    start_prog();
    build(6'b100001, 0, 3, 1'b0);
    run_trace(4);
    start_prog();
    build(6'b000110, 2, 0, 1'b0);
    build(6'b111111, 0, 0, 1'b0);
    run_trace(-1);

    // Reset while instruction fetch is stalled.
    do_reset();
    start_prog();
    build(6'b000011, 3, 0, 1'b0);
    run_trace(2);

    for (int p = 0; p < 20; p++) begin
      do_reset();
      start_prog();
      for (int n = 0; n < int'($urandom_range(3, 10)); n++)
        build(rand_legal(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb());
      if (rb()) build(6'b111111, int'($urandom_range(0, 2)), 0, 1'b0);
      else      build(rand_illegal(), int'($urandom_range(0, 2)), 0, 1'b0);
      run_trace(-1);
    end

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
